// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment display. Each digit owns one refresh slot of REFRESH_DIV
// cycles. The first BLANK_CYCLES of every slot are dark, which avoids ghosting.
// A loaded frame is held in a pending register set. It moves to the display
// set only at a frame boundary, so a scan never mixes old and new data.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zeros.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [7:0]              seg_out,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]       tick;
  logic [IDX_W-1:0]        idx;
  logic                    tick_wrap;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] pend_digits, disp_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   pend_en, disp_en;
  logic                    pend_flag;

  logic [NUM_DIGITS-1:0]   en_eff;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  assign tick_wrap = (tick == TICK_LAST);
  assign boundary  = tick_wrap && (idx == IDX_LAST);

  // Slot timer and digit index; idx advances once per completed slot.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge and block order is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick_wrap) begin
      tick <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Double-buffered frame: load fills the pending set, boundary commits it.
  // NOTE: these register sets are plain flops, not RAM, so they reset to
  // zero; a reset mid-frame discards both sets and the display stays dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_flag   <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_en     <= '0;
    end else if (boundary && load) begin
      // A load that lands on the boundary goes straight to the display.
      disp_digits <= digits_in;
      disp_dp     <= dp_in;
      disp_en     <= digit_en_in;
      pend_flag   <= 1'b0;
    end else if (boundary && pend_flag) begin
      disp_digits <= pend_digits;
      disp_dp     <= pend_dp;
      disp_en     <= pend_en;
      pend_flag   <= 1'b0;
    end else if (load) begin
      pend_digits <= digits_in;
      pend_dp     <= dp_in;
      pend_en     <= digit_en_in;
      pend_flag   <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Darken zero digits (dp off) above the highest nonzero enabled digit.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    logic scanning;
    en_eff   = disp_en;
    scanning = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_en[i] && (disp_digits[4*i +: 4] != 4'h0)) begin
        scanning = 1'b0;
      end else if (scanning && (disp_digits[4*i +: 4] == 4'h0) && !disp_dp[i]) begin
        en_eff[i] = 1'b0;
      end
    end
  end
`else
  assign en_eff = disp_en;
`endif

  // Next anode and segment pattern for the current slot position.
  always_comb begin
    an_next  = '1;
    seg_next = 8'hFF;
    if ((int'(tick) >= BLANK_CYCLES) && en_eff[idx]) begin
      an_next[idx] = 1'b0;
      seg_next     = {~disp_dp[idx], enc(disp_digits[4*idx +: 4])};
    end
  end

  // Register the pin outputs, one cycle behind the counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out      <= '1;
      seg_out     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an_out      <= an_next;
      seg_out     <= seg_next;
      frame_start <= (tick == '0) && (idx == '0);
    end
  end

  assign pending = pend_flag;

endmodule
